// File: rtl/sipo_ctrl_pkg.sv
// rtl/sipo_ctrl_pkg.sv - shared state encoding for the SIPO frame controller
package sipo_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - left-shifting serial-in shift register, MSB first
module sipo_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Shift register: clear wins over shift so an aborted frame never leaks a bit
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_q <= '0;
    end else if (shift_en) begin
      r_q <= {r_q[WIDTH-2:0], din};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - SIPO frame controller; optional parity via SIPO_PARITY_EN
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             serial_data_in,
  input  logic             out_ready,
  input  logic             clear_err,
  output logic [WIDTH-1:0] parallel_data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_pdo;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_overrun;

  logic             w_clr;
  logic             w_shift;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_load;
  logic             w_ovr_set;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_load_word;
  logic             w_unused_msb;

  sipo_shift_core #(
    .WIDTH(WIDTH)
  ) u_shift_core (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_clr),
    .shift_en(w_shift),
    .din     (serial_data_in),
    .q       (w_q)
  );

  // The completed word is the register contents after the final shift,
  // formed here so it can be captured on the same edge as the last bit.
  assign w_load_word  = {w_q[WIDTH-2:0], serial_data_in};
  assign w_unused_msb = w_q[WIDTH-1];

`ifdef SIPO_PARITY_EN
  logic r_parity_err;
  logic w_par_fail;
`endif

  // Next-state and control decode; start aborts any partial frame
  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_shift   = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_load    = 1'b0;
    w_ovr_set = 1'b0;
`ifdef SIPO_PARITY_EN
    w_par_fail = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clr     = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (start) begin
          w_clr     = 1'b1;
          w_cnt_clr = 1'b1;
        end else if (bit_valid) begin
          w_shift   = 1'b1;
          w_cnt_inc = 1'b1;
          if (r_cnt == LAST_IDX) begin
            w_load = 1'b1;
`ifdef SIPO_PARITY_EN
            w_next = ST_PARITY;
`else
            w_next = ST_HOLD;
`endif
          end
        end
      end
`ifdef SIPO_PARITY_EN
      ST_PARITY: begin
        if (start) begin
          w_clr     = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = ST_SHIFT;
        end else if (bit_valid) begin
          w_par_fail = ^{r_pdo, serial_data_in};
          w_next     = ST_HOLD;
        end
      end
`endif
      ST_HOLD: begin
        if (out_ready) begin
          if (start) begin
            w_clr     = 1'b1;
            w_cnt_clr = 1'b1;
            w_next    = ST_SHIFT;
          end else begin
            w_next = ST_IDLE;
          end
        end else if (bit_valid) begin
          w_ovr_set = 1'b1;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Bit counter; saturates at WIDTH because the frame leaves SHIFT on the last bit
  always_ff @(posedge clk) begin
    if (reset || w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Output word: changes only when a frame's last data bit is captured
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pdo <= '0;
    end else if (w_load) begin
      r_pdo <= w_load_word;
    end
  end

  // Registered status derived from the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= (w_next == ST_HOLD);
      r_busy      <= (w_next == ST_SHIFT) || (w_next == ST_PARITY);
    end
  end

  // Sticky overrun; a new event on the same edge beats clear_err
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (clear_err) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_EN
  // Sticky parity error; a new mismatch on the same edge beats clear_err
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity_err <= 1'b0;
    end else if (w_par_fail) begin
      r_parity_err <= 1'b1;
    end else if (clear_err) begin
      r_parity_err <= 1'b0;
    end
  end
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign parallel_data_out = r_pdo;
  assign out_valid         = r_out_valid;
  assign busy              = r_busy;
  assign overrun           = r_overrun;

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Frame controller for the left-shifting serial-in/parallel-out datapath. It sequences WIDTH serial bits into a parallel word: frame start, per-bit qualification, bit counting, and presenting the completed word on a valid/ready output handshake. It sits between a serial source (bit-qualified stream) and a parallel consumer, and flags overrun when bits arrive while a word is still unclaimed.

## Interface
- WIDTH, default 4: bits per frame; legal range 2..32.
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high; all state cleared on the clk edge where reset=1.
- start  input  1  frame start pulse; begins a new frame.
- bit_valid  input  1  qualifies serial_data_in on this edge.
- serial_data_in  input  1  serial bit, MSB first.
- out_ready  input  1  consumer accepts parallel_data_out.
- clear_err  input  1  clears sticky error flags.
- parallel_data_out  output  WIDTH  completed word, held stable while out_valid=1.
- out_valid  output  1  word available.
- busy  output  1  frame in progress (states SHIFT/PARITY).
- overrun  output  1  sticky: bit_valid seen in HOLD.
- parity_err  output  1  sticky: parity mismatch (only with SIPO_PARITY_EN; otherwise tied 0).

## Operation
- States: IDLE, SHIFT, PARITY (only with SIPO_PARITY_EN), HOLD.
- IDLE: start=1 -> clear shift register and bit count, go SHIFT. bit_valid ignored.
- SHIFT: on each bit_valid=1 edge, sr <= {sr[WIDTH-2:0], serial_data_in}; count++. On the WIDTH-th valid bit, load parallel_data_out with the final shifted value, go PARITY (enabled) or HOLD.
- PARITY: next bit_valid=1 samples the parity bit; even parity over the word plus parity bit must equal 0, else set parity_err. Go HOLD. The word is still delivered.
- HOLD: out_valid=1. out_ready=1 completes the transfer: go IDLE, or SHIFT if start=1 on the same edge (counter cleared).
- start=1 in SHIFT/PARITY: abort; discard partial word, clear count, remain/return to SHIFT. No flag.
- start=1 in HOLD without out_ready: ignored.
- bit_valid=1 in HOLD (and not accepted on that edge): bit dropped, overrun <= 1.
- clear_err=1 clears overrun and parity_err; a new error event on the same edge wins (flag stays 1).
- Bit count width: $clog2(WIDTH+1); it never exceeds WIDTH.

## Timing
- Reset values: parallel_data_out=0, out_valid=0, busy=0, overrun=0, parity_err=0; state IDLE.
- First data bit can be accepted the edge after start, and no earlier.
- out_valid rises on the edge that samples the last data bit (or the parity bit), so it is visible the following cycle. Minimum start-to-out_valid is WIDTH (+1 with parity) edges.
- out_valid falls on the edge where out_valid & out_ready=1. parallel_data_out changes only on load.
- Reset mid-frame or in HOLD: discards the word, out_valid drops immediately on that edge.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- SIPO_PARITY_EN defined: PARITY state present; each frame carries WIDTH data bits plus one even-parity bit, and parity_err is live.
- SIPO_PARITY_EN undefined: no PARITY state; frames are WIDTH bits; parity_err is constant 0.

## Structure
- Package sipo_ctrl_pkg holds the state enum typedef (IDLE/SHIFT/PARITY/HOLD) and its encoding width.
- Sub-module sipo_shift_core (WIDTH parameter; clk, reset, clr, shift_en, din, q) is the shift register. The controller drives clr and shift_en.

## Test plan
- WIDTH=4, reset 2 cycles, start, bits 1,1,0,1 with bit_valid -> out_valid next cycle, parallel_data_out=4'b1101, busy=0; out_ready=1 -> out_valid=0, IDLE.
- Gapped bit_valid (1,_,1,_,_,0,1) -> same 4'b1101; gaps do not advance the count.
- Hold out_ready=0, send a bit_valid in HOLD -> overrun=1, word stays 4'b1101; clear_err -> overrun=0.
- start after 2 bits (1,0), then 0,1,1,0 -> 4'b0110; partial bits discarded.
- In HOLD, out_ready=1 and start=1 together, then bits 1,0,0,0 -> second word 4'b1000 with no idle cycle.
- SIPO_PARITY_EN: data 1,1,0,1 + parity 1 -> parity_err=0; data 1,1,0,1 + parity 0 -> parity_err=1, word still 4'b1101. Reset asserted mid-frame -> all outputs 0 next cycle.
